// File: rtl/msgpass_rqst_addr_seq.sv
// Multi-channel read-address sequencer for the message-pass buffer.
// Each channel sweeps base+offset (mod DEPTH). The sweep is one-shot or circular, with per-channel stall.
module msgpass_rqst_addr_seq #(
  parameter int unsigned CH_NUM     = 2,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned WRAP_WIDTH = 4
) (
  input  logic                           sys_clk,
  input  logic                           rst,
  input  logic                           read_begin_i,
  input  logic                           read_end_i,
  input  logic                           circular_en_i,
  input  logic [CH_NUM*ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [ADDR_WIDTH-1:0]          last_off_i,
  input  logic [CH_NUM-1:0]              is_drc_i,
  output logic [CH_NUM*ADDR_WIDTH-1:0]   addr_o,
  output logic [CH_NUM-1:0]              addr_vld_o,
  output logic                           cen_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [CH_NUM*WRAP_WIDTH-1:0]   wrap_cnt_o
);

  localparam int unsigned DrainW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [DrainW-1:0]     DrainLast = DrainW'(RD_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0]   DepthW    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [WRAP_WIDTH-1:0] WrapMax   = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           off_q [CH_NUM];
  logic [ADDR_WIDTH-1:0]           off_d [CH_NUM];
  logic [CH_NUM-1:0]               fin_q, fin_d;
  logic [CH_NUM*ADDR_WIDTH-1:0]    base_q, base_d;
  logic [ADDR_WIDTH-1:0]           last_q, last_d;
  logic                            circ_q, circ_d;
  logic [DrainW-1:0]               drain_q, drain_d;
  logic [CH_NUM*ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [CH_NUM-1:0]               vld_q, vld_d;
  logic                            cen_q, cen_d, busy_q, busy_d, done_q, done_d;
  logic [CH_NUM*WRAP_WIDTH-1:0]    wrap_q, wrap_d;
  logic                            all_fin;

  // Sum on ADDR_WIDTH+1 bits so the modulo never carries into the base.
  function automatic logic [ADDR_WIDTH-1:0] addr_wrap(input logic [ADDR_WIDTH-1:0] b,
                                                      input logic [ADDR_WIDTH-1:0] o);
    logic [ADDR_WIDTH:0] sum;
    sum = {1'b0, b} + {1'b0, o};
    if (sum >= DepthW) sum = sum - DepthW;
    return sum[ADDR_WIDTH-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    fin_d   = fin_q;
    base_d  = base_q;
    last_d  = last_q;
    circ_d  = circ_q;
    drain_d = drain_q;
    addr_d  = addr_q;
    wrap_d  = wrap_q;
    vld_d   = '0;
    cen_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    all_fin = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (read_begin_i) begin
          state_d = StRun;
          base_d  = base_addr_i;
          last_d  = last_off_i;
          circ_d  = circular_en_i;
          fin_d   = '0;
          wrap_d  = '0;
          vld_d   = '1;
          cen_d   = 1'b1;
          busy_d  = 1'b1;
          for (int unsigned c = 0; c < CH_NUM; c++) begin
            off_d[c] = '0;
            addr_d[c*ADDR_WIDTH +: ADDR_WIDTH] =
              addr_wrap(base_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH], '0);
          end
        end
      end
      StRun: begin
        cen_d  = 1'b1;
        busy_d = 1'b1;
        if (read_end_i) begin
          // Stop request freezes offsets, addresses and wrap counts as they are.
          state_d = StDrain;
          drain_d = '0;
        end else begin
          for (int unsigned c = 0; c < CH_NUM; c++) begin
            if (!fin_q[c] && !is_drc_i[c]) begin
              if (off_q[c] != last_q) begin
                off_d[c] = off_q[c] + ADDR_WIDTH'(1);
              end else if (circ_q) begin
                off_d[c] = '0;
                if (wrap_q[c*WRAP_WIDTH +: WRAP_WIDTH] != WrapMax) begin
                  wrap_d[c*WRAP_WIDTH +: WRAP_WIDTH] =
                    wrap_q[c*WRAP_WIDTH +: WRAP_WIDTH] + WRAP_WIDTH'(1);
                end
              end else begin
                fin_d[c] = 1'b1;
              end
            end
            addr_d[c*ADDR_WIDTH +: ADDR_WIDTH] =
              addr_wrap(base_q[c*ADDR_WIDTH +: ADDR_WIDTH], off_d[c]);
            vld_d[c] = ~fin_d[c];
            all_fin  = all_fin & fin_d[c];
          end
          if (all_fin) begin
            state_d = StDrain;
            drain_d = '0;
          end
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + DrainW'(1);
          cen_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      for (int unsigned c = 0; c < CH_NUM; c++) off_q[c] <= '0;
      fin_q   <= '0;
      base_q  <= '0;
      last_q  <= '0;
      circ_q  <= 1'b0;
      drain_q <= '0;
      addr_q  <= '0;
      vld_q   <= '0;
      cen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= '0;
    end else begin
      state_q <= state_d;
      for (int unsigned c = 0; c < CH_NUM; c++) off_q[c] <= off_d[c];
      fin_q   <= fin_d;
      base_q  <= base_d;
      last_q  <= last_d;
      circ_q  <= circ_d;
      drain_q <= drain_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      cen_q   <= cen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign addr_o     = addr_q;
  assign addr_vld_o = vld_q;
  assign cen_o      = cen_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign wrap_cnt_o = wrap_q;

endmodule

// File: tb/tb_msgpass_rqst_addr_seq.sv
// Directed bench for msgpass_rqst_addr_seq: vector table plus reset and saturation sequences.
module tb_msgpass_rqst_addr_seq;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       read_begin_i, read_end_i, circular_en_i;
  logic [7:0] base_addr_i;
  logic [3:0] last_off_i;
  logic [1:0] is_drc_i;
  logic [7:0] addr_o;
  logic [1:0] addr_vld_o;
  logic       cen_o, busy_o, done_o;
  logic [7:0] wrap_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  msgpass_rqst_addr_seq #(
    .CH_NUM(2), .ADDR_WIDTH(4), .DEPTH(16), .RD_LATENCY(1), .WRAP_WIDTH(4)
  ) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .read_begin_i  (read_begin_i),
    .read_end_i    (read_end_i),
    .circular_en_i (circular_en_i),
    .base_addr_i   (base_addr_i),
    .last_off_i    (last_off_i),
    .is_drc_i      (is_drc_i),
    .addr_o        (addr_o),
    .addr_vld_o    (addr_vld_o),
    .cen_o         (cen_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .wrap_cnt_o    (wrap_cnt_o)
  );

  // Output bundle: {addr[7:0], vld[1:0], cen, busy, done, wrap[7:0]}
  logic [20:0] got;
  assign got = {addr_o, addr_vld_o, cen_o, busy_o, done_o, wrap_cnt_o};

  typedef struct {
    string      name;
    logic       b, e, c;
    logic [7:0] base;
    logic [3:0] last;
    logic [1:0] drc;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic b, input logic e, input logic c,
                     input logic [7:0] base, input logic [3:0] last, input logic [1:0] drc,
                     input logic [7:0] a, input logic [1:0] v, input logic cen,
                     input logic bsy, input logic dn, input logic [7:0] w);
    vec_t t;
    t.name = name; t.b = b; t.e = e; t.c = c; t.base = base; t.last = last; t.drc = drc;
    t.exp = {a, v, cen, bsy, dn, w};
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got addr=%h vld=%b cen=%b busy=%b done=%b wrap=%h, want addr=%h vld=%b cen=%b busy=%b done=%b wrap=%h",
               name, act[20:13], act[12:11], act[10], act[9], act[8], act[7:0],
               exp[20:13], exp[12:11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic drive(input logic b, input logic e, input logic c, input logic [7:0] base,
                       input logic [3:0] last, input logic [1:0] drc);
    read_begin_i = b; read_end_i = e; circular_en_i = c;
    base_addr_i = base; last_off_i = last; is_drc_i = drc;
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    logic [3:0] w;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 2'b00);
    rst = 1'b1;
    #12;
    check("reset_state", got, 21'h0);
    rst = 1'b0;
    step();

    // One-shot, bases 0/8, last=3
    add("os_begin", 1, 0, 0, 8'h80, 4'd3, 2'b00, 8'h80, 2'b11, 1, 1, 0, 8'h00);
    add("os_run1",  0, 0, 0, 8'h80, 4'd3, 2'b00, 8'h91, 2'b11, 1, 1, 0, 8'h00);
    add("os_run2",  0, 0, 0, 8'h80, 4'd3, 2'b00, 8'hA2, 2'b11, 1, 1, 0, 8'h00);
    add("os_run3",  0, 0, 0, 8'h80, 4'd3, 2'b00, 8'hB3, 2'b11, 1, 1, 0, 8'h00);
    add("os_drain", 0, 0, 0, 8'h80, 4'd3, 2'b00, 8'hB3, 2'b00, 1, 1, 0, 8'h00);
    add("os_done",  0, 0, 0, 8'h80, 4'd3, 2'b00, 8'hB3, 2'b00, 0, 0, 1, 8'h00);
    add("os_idle",  0, 0, 0, 8'h80, 4'd3, 2'b00, 8'hB3, 2'b00, 0, 0, 0, 8'h00);
    // DRC stall on ch0 during the 2nd RUN cycle
    add("drc_begin", 1, 0, 0, 8'h80, 4'd3, 2'b00, 8'h80, 2'b11, 1, 1, 0, 8'h00);
    add("drc_run1",  0, 0, 0, 8'h80, 4'd3, 2'b00, 8'h91, 2'b11, 1, 1, 0, 8'h00);
    add("drc_stall", 0, 0, 0, 8'h80, 4'd3, 2'b01, 8'hA1, 2'b11, 1, 1, 0, 8'h00);
    add("drc_run3",  0, 0, 0, 8'h80, 4'd3, 2'b00, 8'hB2, 2'b11, 1, 1, 0, 8'h00);
    add("drc_ch1fin",0, 0, 0, 8'h80, 4'd3, 2'b00, 8'hB3, 2'b01, 1, 1, 0, 8'h00);
    add("drc_drain", 0, 0, 0, 8'h80, 4'd3, 2'b10, 8'hB3, 2'b00, 1, 1, 0, 8'h00);
    add("drc_done",  0, 0, 0, 8'h80, 4'd3, 2'b00, 8'hB3, 2'b00, 0, 0, 1, 8'h00);
    // Circular, ch0 base 14 wraps modulo 16, ch1 base 2
    add("cir_begin", 1, 0, 1, 8'h2E, 4'd3, 2'b00, 8'h2E, 2'b11, 1, 1, 0, 8'h00);
    add("cir_run1",  0, 0, 0, 8'h2E, 4'd3, 2'b00, 8'h3F, 2'b11, 1, 1, 0, 8'h00);
    add("cir_modwrap",0,0, 0, 8'h2E, 4'd3, 2'b00, 8'h40, 2'b11, 1, 1, 0, 8'h00);
    add("cir_run3",  0, 0, 0, 8'h2E, 4'd3, 2'b00, 8'h51, 2'b11, 1, 1, 0, 8'h00);
    add("cir_wrap1", 0, 0, 0, 8'h2E, 4'd3, 2'b00, 8'h2E, 2'b11, 1, 1, 0, 8'h11);
    add("cir_run5",  0, 0, 0, 8'h2E, 4'd3, 2'b00, 8'h3F, 2'b11, 1, 1, 0, 8'h11);
    add("cir_end",   0, 1, 0, 8'h2E, 4'd3, 2'b00, 8'h3F, 2'b00, 1, 1, 0, 8'h11);
    add("cir_done",  0, 0, 0, 8'h2E, 4'd3, 2'b00, 8'h3F, 2'b00, 0, 0, 1, 8'h11);
    // Collisions: begin+end in IDLE, begin in RUN, end at last offset
    add("col_beg_end",1, 1, 0, 8'h80, 4'd2, 2'b00, 8'h80, 2'b11, 1, 1, 0, 8'h00);
    add("col_beg_run",1, 0, 0, 8'h35, 4'd2, 2'b00, 8'h91, 2'b11, 1, 1, 0, 8'h00);
    add("col_last",  0, 0, 0, 8'h80, 4'd2, 2'b00, 8'hA2, 2'b11, 1, 1, 0, 8'h00);
    add("col_end",   0, 1, 0, 8'h80, 4'd2, 2'b00, 8'hA2, 2'b00, 1, 1, 0, 8'h00);
    add("col_done",  0, 1, 0, 8'h80, 4'd2, 2'b00, 8'hA2, 2'b00, 0, 0, 1, 8'h00);
    add("col_single",0, 0, 0, 8'h80, 4'd2, 2'b00, 8'hA2, 2'b00, 0, 0, 0, 8'h00);

    foreach (vecs[i]) begin
      drive(vecs[i].b, vecs[i].e, vecs[i].c, vecs[i].base, vecs[i].last, vecs[i].drc);
      step();
      check(vecs[i].name, got, vecs[i].exp);
    end

    // Saturation: circular, last=0, wrap count climbs every cycle and sticks at 15
    drive(1'b1, 1'b0, 1'b1, 8'h53, 4'd0, 2'b00);
    step();
    check("sat_begin", got, {8'h53, 2'b11, 1'b1, 1'b1, 1'b0, 8'h00});
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 2'b00);
    for (int k = 1; k <= 20; k++) begin
      step();
      w = (k > 15) ? 4'hF : 4'(k);
      check($sformatf("sat_cyc%0d", k), got, {8'h53, 2'b11, 1'b1, 1'b1, 1'b0, w, w});
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 2'b00);
    step();
    check("sat_end", got, {8'h53, 2'b00, 1'b1, 1'b1, 1'b0, 8'hFF});
    drive(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 2'b00);
    step();
    check("sat_done", got, {8'h53, 2'b00, 1'b0, 1'b0, 1'b1, 8'hFF});

    // Async reset mid-RUN at offset 3
    drive(1'b1, 1'b0, 1'b0, 8'h80, 4'd5, 2'b00);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h80, 4'd5, 2'b00);
    step();
    step();
    step();
    check("rst_pre", got, {8'hB3, 2'b11, 1'b1, 1'b1, 1'b0, 8'h00});
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", got, 21'h0);
    step();
    check("rst_held", got, 21'h0);
    rst = 1'b0;
    step();
    check("rst_nodone", got, 21'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
